// File: rtl/hs_fifo_buf_if.sv
// Handshake bundle between sender, buffer and receiver.
// The buffer takes the slave view; the environment driving it takes the master view.
interface hs_fifo_buf_if #(
    parameter int WIDTH = 32
);
    logic             StoB_REQ;
    logic [WIDTH-1:0] DI;
    logic             BtoS_ACK;
    logic             BtoR_REQ;
    logic [WIDTH-1:0] DO;
    logic             RtoB_ACK;

    modport slave (
        input  StoB_REQ, DI, RtoB_ACK,
        output BtoS_ACK, BtoR_REQ, DO
    );

    modport master (
        output StoB_REQ, DI, RtoB_ACK,
        input  BtoS_ACK, BtoR_REQ, DO
    );
endinterface

// File: rtl/hs_fifo_buf.sv
// DEPTH-entry FIFO between two 4-phase REQ/ACK handshakes, with optional input
// synchronisers and a sticky flag for receiver protocol violations.
module hs_fifo_buf #(
    parameter int WIDTH       = 32,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    hs_fifo_buf_if.slave                 bus,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         proto_err
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {I_IDLE, I_ACK} in_state_e;
    typedef enum logic [1:0] {O_IDLE, O_SETUP, O_REQ, O_WAIT} out_state_e;

    in_state_e        in_state_q;
    out_state_e       out_state_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] do_q;
    logic             sack_q, breq_q, err_q, ack_prev_q;
    logic             req_s, ack_s;
    logic             wr_en, rel_en;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign req_s = bus.StoB_REQ;
            assign ack_s = bus.RtoB_ACK;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] req_sync_q, ack_sync_q;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    req_sync_q <= '0;
                    ack_sync_q <= '0;
                end else begin
                    req_sync_q[0] <= bus.StoB_REQ;
                    ack_sync_q[0] <= bus.RtoB_ACK;
                    for (int i = 1; i < SYNC_STAGES; i++) begin
                        req_sync_q[i] <= req_sync_q[i-1];
                        ack_sync_q[i] <= ack_sync_q[i-1];
                    end
                end
            end
            assign req_s = req_sync_q[SYNC_STAGES-1];
            assign ack_s = ack_sync_q[SYNC_STAGES-1];
        end
    endgenerate

    // Fullness uses the pre-edge count, so a release on the same edge does not unblock a write.
    assign wr_en  = (in_state_q == I_IDLE) && req_s && (count_q != CW'(DEPTH));
    assign rel_en = (out_state_q == O_REQ) && ack_s;

    always_comb begin
        count_d = count_q;
        if (wr_en && !rel_en)
            count_d = count_q + 1'b1;
        else if (!wr_en && rel_en)
            count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            mem_q[wr_ptr_q] <= bus.DI;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count_q <= '0;
        else
            count_q <= count_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_state_q <= I_IDLE;
            sack_q     <= 1'b0;
            wr_ptr_q   <= '0;
        end else begin
            case (in_state_q)
                I_IDLE: if (wr_en) begin
                    wr_ptr_q   <= ptr_inc(wr_ptr_q);
                    sack_q     <= 1'b1;
                    in_state_q <= I_ACK;
                end
                I_ACK: if (!req_s) begin
                    sack_q     <= 1'b0;
                    in_state_q <= I_IDLE;
                end
                default: in_state_q <= I_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_state_q <= O_IDLE;
            breq_q      <= 1'b0;
            do_q        <= '0;
            rd_ptr_q    <= '0;
            err_q       <= 1'b0;
            ack_prev_q  <= 1'b0;
        end else begin
            ack_prev_q <= ack_s;
            // An ACK before REQ, or a fresh ACK after the release, is a receiver fault.
            if ((ack_s && (out_state_q == O_IDLE || out_state_q == O_SETUP)) ||
                (ack_s && !ack_prev_q && out_state_q == O_WAIT))
                err_q <= 1'b1;
            case (out_state_q)
                O_IDLE: if (count_q != '0) begin
                    do_q        <= mem_q[rd_ptr_q];
                    out_state_q <= O_SETUP;
                end
                O_SETUP: begin
                    breq_q      <= 1'b1;
                    out_state_q <= O_REQ;
                end
                O_REQ: if (ack_s) begin
                    breq_q      <= 1'b0;
                    rd_ptr_q    <= ptr_inc(rd_ptr_q);
                    out_state_q <= O_WAIT;
                end
                O_WAIT: if (!ack_s)
                    out_state_q <= O_IDLE;
                default: out_state_q <= O_IDLE;
            endcase
        end
    end

    assign bus.BtoS_ACK = sack_q;
    assign bus.BtoR_REQ = breq_q;
    assign bus.DO       = do_q;
    assign count        = count_q;
    assign proto_err    = err_q;
endmodule

// File: tb/tb_hs_fifo_buf.sv
// Directed bench for hs_fifo_buf: a default instance (2 sync stages) and an
// unsynchronised instance sharing clk/rst.
module tb_hs_fifo_buf;
    logic       clk;
    logic       rst;
    logic [2:0] count0, count1;
    logic       err0, err1;
    int         vectors;
    int         miscompares;
    int         ack_rises;

    hs_fifo_buf_if #(.WIDTH(32)) a0 ();
    hs_fifo_buf_if #(.WIDTH(32)) a1 ();

    hs_fifo_buf #(.WIDTH(32), .DEPTH(4), .SYNC_STAGES(2)) u_dut0 (
        .clk(clk), .rst(rst), .bus(a0.slave), .count(count0), .proto_err(err0));
    hs_fifo_buf #(.WIDTH(32), .DEPTH(4), .SYNC_STAGES(0)) u_dut1 (
        .clk(clk), .rst(rst), .bus(a1.slave), .count(count1), .proto_err(err1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial ack_rises = 0;
    always @(posedge a0.BtoS_ACK) ack_rises++;

    task automatic do_reset();
        rst = 1'b1;
        a0.StoB_REQ = 1'b0; a0.RtoB_ACK = 1'b0; a0.DI = '0;
        a1.StoB_REQ = 1'b0; a1.RtoB_ACK = 1'b0; a1.DI = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Full 4-phase push on instance 0; ok=0 if an ACK edge never arrives.
    task automatic send_word(input logic [31:0] w, output bit ok);
        int n;
        ok = 1'b1;
        a0.DI = w;
        a0.StoB_REQ = 1'b1;
        n = 0;
        while (a0.BtoS_ACK !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        if (a0.BtoS_ACK !== 1'b1) ok = 1'b0;
        a0.StoB_REQ = 1'b0;
        n = 0;
        while (a0.BtoS_ACK !== 1'b0 && n < 100) begin @(negedge clk); n++; end
        if (a0.BtoS_ACK !== 1'b0) ok = 1'b0;
    endtask

    // Full 4-phase pop on instance 0, ACKing dly cycles after REQ is seen.
    task automatic recv_word(input int dly, output logic [31:0] w, output bit ok);
        int n;
        ok = 1'b1;
        w = '0;
        n = 0;
        while (a0.BtoR_REQ !== 1'b1 && n < 200) begin @(negedge clk); n++; end
        if (a0.BtoR_REQ !== 1'b1) begin
            ok = 1'b0;
            return;
        end
        w = a0.DO;
        repeat (dly) @(negedge clk);
        a0.RtoB_ACK = 1'b1;
        n = 0;
        while (a0.BtoR_REQ !== 1'b0 && n < 100) begin @(negedge clk); n++; end
        if (a0.BtoR_REQ !== 1'b0) ok = 1'b0;
        a0.RtoB_ACK = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        a0.StoB_REQ = 1'b0; a0.RtoB_ACK = 1'b0; a0.DI = '0;
        a1.StoB_REQ = 1'b0; a1.RtoB_ACK = 1'b0; a1.DI = '0;
        @(negedge clk);
        vectors++; if (a0.BtoS_ACK !== 1'b0) begin miscompares++; $display("FAIL rst_sack0: got %0b expected 0", a0.BtoS_ACK); end
        vectors++; if (a0.BtoR_REQ !== 1'b0) begin miscompares++; $display("FAIL rst_breq0: got %0b expected 0", a0.BtoR_REQ); end
        vectors++; if (a0.DO !== 32'h0) begin miscompares++; $display("FAIL rst_do0: got %0h expected 0", a0.DO); end
        vectors++; if (count0 !== 3'd0) begin miscompares++; $display("FAIL rst_count0: got %0d expected 0", count0); end
        vectors++; if (err0 !== 1'b0) begin miscompares++; $display("FAIL rst_err0: got %0b expected 0", err0); end
        vectors++; if (count1 !== 3'd0 || a1.BtoR_REQ !== 1'b0 || a1.BtoS_ACK !== 1'b0 || err1 !== 1'b0)
            begin miscompares++; $display("FAIL rst_dut1: got cnt=%0d req=%0b ack=%0b err=%0b expected all 0", count1, a1.BtoR_REQ, a1.BtoS_ACK, err1); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_latency();
        bit ok;
        logic [31:0] w;
        do_reset();
        a0.DI = 32'h5A; a0.StoB_REQ = 1'b1;
        repeat (2) @(negedge clk);
        vectors++; if (a0.BtoS_ACK !== 1'b0) begin miscompares++; $display("FAIL lat_ack_e2: got %0b expected 0", a0.BtoS_ACK); end
        @(negedge clk);
        vectors++; if (a0.BtoS_ACK !== 1'b1 || count0 !== 3'd1) begin miscompares++; $display("FAIL lat_ack_e3: got ack=%0b cnt=%0d expected ack=1 cnt=1", a0.BtoS_ACK, count0); end
        @(negedge clk);
        vectors++; if (a0.DO !== 32'h5A || a0.BtoR_REQ !== 1'b0) begin miscompares++; $display("FAIL lat_do_e4: got do=%0h req=%0b expected do=5a req=0", a0.DO, a0.BtoR_REQ); end
        @(negedge clk);
        vectors++; if (a0.BtoR_REQ !== 1'b1) begin miscompares++; $display("FAIL lat_req_e5: got %0b expected 1", a0.BtoR_REQ); end
        a0.StoB_REQ = 1'b0;
        repeat (4) @(negedge clk);
        recv_word(0, w, ok);
        vectors++; if (!ok || w !== 32'h5A) begin miscompares++; $display("FAIL lat_recv: got %0h ok=%0b expected 5a", w, ok); end
    endtask

    task automatic test_push3();
        bit ok;
        int r0;
        do_reset();
        r0 = ack_rises;
        for (int i = 0; i < 3; i++) begin
            send_word(32'(i), ok);
            vectors++; if (!ok) begin miscompares++; $display("FAIL push3_hs%0d: got no handshake expected handshake", i); end
            vectors++; if (count0 !== 3'(i + 1)) begin miscompares++; $display("FAIL push3_count%0d: got %0d expected %0d", i, count0, i + 1); end
        end
        repeat (4) @(negedge clk);
        vectors++; if (a0.BtoR_REQ !== 1'b1 || a0.DO !== 32'h0) begin miscompares++; $display("FAIL push3_out: got req=%0b do=%0h expected req=1 do=0", a0.BtoR_REQ, a0.DO); end
        vectors++; if (ack_rises - r0 !== 3) begin miscompares++; $display("FAIL push3_pulses: got %0d expected 3", ack_rises - r0); end
        vectors++; if (err0 !== 1'b0) begin miscompares++; $display("FAIL push3_err: got %0b expected 0", err0); end
    endtask

    task automatic test_full();
        bit ok;
        int n;
        logic [31:0] w;
        do_reset();
        for (int i = 0; i < 4; i++) send_word(32'(10 + i), ok);
        vectors++; if (count0 !== 3'd4) begin miscompares++; $display("FAIL full_count4: got %0d expected 4", count0); end
        a0.DI = 32'd14; a0.StoB_REQ = 1'b1;
        repeat (10) @(negedge clk);
        vectors++; if (a0.BtoS_ACK !== 1'b0 || count0 !== 3'd4) begin miscompares++; $display("FAIL full_stall: got ack=%0b cnt=%0d expected ack=0 cnt=4", a0.BtoS_ACK, count0); end
        recv_word(0, w, ok);
        vectors++; if (!ok || w !== 32'd10) begin miscompares++; $display("FAIL full_pop10: got %0d ok=%0b expected 10", w, ok); end
        n = 0;
        while (a0.BtoS_ACK !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        vectors++; if (a0.BtoS_ACK !== 1'b1) begin miscompares++; $display("FAIL full_late_ack: got %0b expected 1", a0.BtoS_ACK); end
        a0.StoB_REQ = 1'b0;
        repeat (4) @(negedge clk);
        vectors++; if (count0 !== 3'd4) begin miscompares++; $display("FAIL full_refill: got %0d expected 4", count0); end
        for (int j = 0; j < 4; j++) begin
            recv_word(0, w, ok);
            vectors++; if (!ok || w !== 32'(11 + j)) begin miscompares++; $display("FAIL full_drain%0d: got %0d ok=%0b expected %0d", j, w, ok, 11 + j); end
        end
        repeat (4) @(negedge clk);
        vectors++; if (count0 !== 3'd0) begin miscompares++; $display("FAIL full_empty: got %0d expected 0", count0); end
    endtask

    task automatic test_stream();
        int s_err;
        int maxc;
        bit done;
        do_reset();
        s_err = 0; maxc = 0; done = 1'b0;
        fork
            begin
                bit ok;
                for (int i = 0; i < 100; i++) begin
                    send_word(32'(i), ok);
                    if (!ok) s_err++;
                end
            end
            begin
                bit ok;
                logic [31:0] w;
                for (int i = 0; i < 100; i++) begin
                    recv_word(3, w, ok);
                    vectors++;
                    if (!ok || w !== 32'(i)) begin miscompares++; $display("FAIL stream_word%0d: got %0d ok=%0b expected %0d", i, w, ok, i); end
                end
                done = 1'b1;
            end
            begin
                int n = 0;
                while (!done && n < 20000) begin
                    @(negedge clk);
                    if (int'(count0) > maxc) maxc = int'(count0);
                    n++;
                end
            end
        join
        repeat (6) @(negedge clk);
        vectors++; if (s_err !== 0) begin miscompares++; $display("FAIL stream_send: got %0d failed pushes expected 0", s_err); end
        vectors++; if (maxc > 4 || maxc < 1) begin miscompares++; $display("FAIL stream_maxcount: got %0d expected 1..4", maxc); end
        vectors++; if (count0 !== 3'd0 || err0 !== 1'b0) begin miscompares++; $display("FAIL stream_end: got cnt=%0d err=%0b expected 0 0", count0, err0); end
    endtask

    task automatic test_simul();
        bit ok;
        logic [31:0] w;
        do_reset();
        send_word(32'hA1, ok);
        send_word(32'hB2, ok);
        repeat (4) @(negedge clk);
        vectors++; if (a0.BtoR_REQ !== 1'b1 || count0 !== 3'd2) begin miscompares++; $display("FAIL sim_pre: got req=%0b cnt=%0d expected req=1 cnt=2", a0.BtoR_REQ, count0); end
        a0.RtoB_ACK = 1'b1; a0.DI = 32'hC3; a0.StoB_REQ = 1'b1;
        repeat (2) @(negedge clk);
        vectors++; if (a0.BtoS_ACK !== 1'b0 || a0.BtoR_REQ !== 1'b1 || count0 !== 3'd2) begin miscompares++; $display("FAIL sim_e2: got ack=%0b req=%0b cnt=%0d expected 0 1 2", a0.BtoS_ACK, a0.BtoR_REQ, count0); end
        @(negedge clk);
        vectors++; if (a0.BtoS_ACK !== 1'b1 || a0.BtoR_REQ !== 1'b0 || count0 !== 3'd2) begin miscompares++; $display("FAIL sim_e3: got ack=%0b req=%0b cnt=%0d expected 1 0 2", a0.BtoS_ACK, a0.BtoR_REQ, count0); end
        a0.RtoB_ACK = 1'b0; a0.StoB_REQ = 1'b0;
        repeat (4) @(negedge clk);
        recv_word(0, w, ok);
        vectors++; if (!ok || w !== 32'hB2) begin miscompares++; $display("FAIL sim_next: got %0h ok=%0b expected b2", w, ok); end
        recv_word(0, w, ok);
        vectors++; if (!ok || w !== 32'hC3) begin miscompares++; $display("FAIL sim_last: got %0h ok=%0b expected c3", w, ok); end
        vectors++; if (err0 !== 1'b0) begin miscompares++; $display("FAIL sim_err: got %0b expected 0", err0); end
    endtask

    task automatic test_proto_err();
        bit ok;
        logic [31:0] w;
        do_reset();
        a0.RtoB_ACK = 1'b1;
        repeat (2) @(negedge clk);
        vectors++; if (err0 !== 1'b0) begin miscompares++; $display("FAIL perr_e2: got %0b expected 0", err0); end
        @(negedge clk);
        vectors++; if (err0 !== 1'b1) begin miscompares++; $display("FAIL perr_e3: got %0b expected 1", err0); end
        a0.RtoB_ACK = 1'b0;
        repeat (5) @(negedge clk);
        vectors++; if (err0 !== 1'b1) begin miscompares++; $display("FAIL perr_sticky: got %0b expected 1", err0); end
        send_word(32'h77, ok);
        recv_word(0, w, ok);
        vectors++; if (!ok || w !== 32'h77) begin miscompares++; $display("FAIL perr_flow: got %0h ok=%0b expected 77", w, ok); end
        vectors++; if (err0 !== 1'b1) begin miscompares++; $display("FAIL perr_hold: got %0b expected 1", err0); end
    endtask

    task automatic test_async_reset();
        bit ok;
        int n;
        logic [31:0] w;
        send_word(32'd1, ok);
        send_word(32'd2, ok);
        a0.DI = 32'd3; a0.StoB_REQ = 1'b1;
        n = 0;
        while (a0.BtoS_ACK !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        repeat (2) @(negedge clk);
        vectors++; if (a0.BtoS_ACK !== 1'b1 || a0.BtoR_REQ !== 1'b1 || count0 !== 3'd3 || a0.DO !== 32'd1)
            begin miscompares++; $display("FAIL arst_pre: got ack=%0b req=%0b cnt=%0d do=%0h expected 1 1 3 1", a0.BtoS_ACK, a0.BtoR_REQ, count0, a0.DO); end
        #2 rst = 1'b1;
        a0.DI = 32'd55;
        #1;
        vectors++; if (a0.BtoR_REQ !== 1'b0 || a0.BtoS_ACK !== 1'b0) begin miscompares++; $display("FAIL arst_hs: got req=%0b ack=%0b expected 0 0", a0.BtoR_REQ, a0.BtoS_ACK); end
        vectors++; if (count0 !== 3'd0 || a0.DO !== 32'h0 || err0 !== 1'b0) begin miscompares++; $display("FAIL arst_state: got cnt=%0d do=%0h err=%0b expected 0 0 0", count0, a0.DO, err0); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        n = 0;
        while (a0.BtoS_ACK !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        vectors++; if (a0.BtoS_ACK !== 1'b1) begin miscompares++; $display("FAIL arst_rereq: got %0b expected 1", a0.BtoS_ACK); end
        a0.StoB_REQ = 1'b0;
        repeat (4) @(negedge clk);
        recv_word(0, w, ok);
        vectors++; if (!ok || w !== 32'd55) begin miscompares++; $display("FAIL arst_first: got %0d ok=%0b expected 55", w, ok); end
        repeat (4) @(negedge clk);
        vectors++; if (count0 !== 3'd0) begin miscompares++; $display("FAIL arst_empty: got %0d expected 0", count0); end
    endtask

    task automatic test_nosync();
        do_reset();
        a1.DI = 32'h99; a1.StoB_REQ = 1'b1;
        @(negedge clk);
        vectors++; if (a1.BtoS_ACK !== 1'b1 || count1 !== 3'd1 || a1.BtoR_REQ !== 1'b0)
            begin miscompares++; $display("FAIL ns_e1: got ack=%0b cnt=%0d req=%0b expected 1 1 0", a1.BtoS_ACK, count1, a1.BtoR_REQ); end
        a1.StoB_REQ = 1'b0;
        @(negedge clk);
        vectors++; if (a1.DO !== 32'h99 || a1.BtoR_REQ !== 1'b0 || a1.BtoS_ACK !== 1'b0)
            begin miscompares++; $display("FAIL ns_e2: got do=%0h req=%0b ack=%0b expected 99 0 0", a1.DO, a1.BtoR_REQ, a1.BtoS_ACK); end
        @(negedge clk);
        vectors++; if (a1.BtoR_REQ !== 1'b1) begin miscompares++; $display("FAIL ns_e3: got %0b expected 1", a1.BtoR_REQ); end
        a1.RtoB_ACK = 1'b1;
        @(negedge clk);
        vectors++; if (a1.BtoR_REQ !== 1'b0 || count1 !== 3'd0) begin miscompares++; $display("FAIL ns_rel: got req=%0b cnt=%0d expected 0 0", a1.BtoR_REQ, count1); end
        a1.RtoB_ACK = 1'b0;
        repeat (3) @(negedge clk);
        vectors++; if (err1 !== 1'b0 || a1.BtoR_REQ !== 1'b0) begin miscompares++; $display("FAIL ns_end: got err=%0b req=%0b expected 0 0", err1, a1.BtoR_REQ); end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_latency();
        test_push3();
        test_full();
        test_stream();
        test_simul();
        test_proto_err();
        test_async_reset();
        test_nosync();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
